// File: rtl/addr_pkg.sv
// Shared sizes and types for the A-register multiply issue stage.
// The tag struct records which A register owns each in-flight product.
package addr_pkg;

  localparam int WIDTH   = 32;
  localparam int NREGS   = 8;
  localparam int IDXW    = 3;
  localparam int LATENCY = 6;

  typedef logic [WIDTH-1:0] a_word_t;
  typedef logic [IDXW-1:0]  a_idx_t;

  typedef struct packed {
    logic   valid;
    a_idx_t idx;
  } tag_t;

  function automatic tag_t make_tag(input logic valid, input a_idx_t idx);
    tag_t t;
    t.valid = valid;
    t.idx   = valid ? idx : '0;
    return t;
  endfunction

endpackage

// File: rtl/addr_tag_pipe.sv
// LATENCY-deep shift register of destination tags.
// It advances every clock; the head is the tag due for writeback at the next edge.
module addr_tag_pipe
  import addr_pkg::*;
#(
  parameter int LATENCY = addr_pkg::LATENCY
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [IDXW-1:0] in_idx,
  output logic            head_valid,
  output logic [IDXW-1:0] head_idx
);

  tag_t stage_reg [LATENCY];
  tag_t stage_next [LATENCY];

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    if (gi == 0) begin : g_head_in
      assign stage_next[gi] = make_tag(in_valid, in_idx);
    end else begin : g_shift
      assign stage_next[gi] = stage_reg[gi-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < LATENCY; n++) begin
        stage_reg[n] <= '0;
      end
    end else begin
      for (int n = 0; n < LATENCY; n++) begin
        stage_reg[n] <= stage_next[n];
      end
    end
  end

  assign head_valid = stage_reg[LATENCY-1].valid;
  assign head_idx   = stage_reg[LATENCY-1].idx;

endmodule

// File: rtl/address_multiply_issue.sv
// Issue/writeback stage for Ai <- Aj*Ak: owns the A register file, launches
// operands to the external fixed-latency multiplier and retires products.
module address_multiply_issue
  import addr_pkg::*;
#(
  parameter int LATENCY = addr_pkg::LATENCY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_iss_valid,
  output logic             o_iss_ready,
  input  logic [IDXW-1:0]  i_iss_i,
  input  logic [IDXW-1:0]  i_iss_j,
  input  logic [IDXW-1:0]  i_iss_k,
  output logic [WIDTH-1:0] o_mul_Aj,
  output logic [WIDTH-1:0] o_mul_Ak,
  input  logic [WIDTH-1:0] i_mul_Ai,
  input  logic             i_wr_en,
  input  logic [IDXW-1:0]  i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_err,
  input  logic [IDXW-1:0]  i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [NREGS-1:0] o_busy,
  output logic             o_wb_valid,
  output logic [IDXW-1:0]  o_wb_addr
);

  a_word_t          a_reg [NREGS];
  a_word_t          a_wdata [NREGS];
  logic [NREGS-1:0] a_we;
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic             iss_fire;
  logic             head_valid;
  a_idx_t           head_idx;

  // No bypass: a register retiring at this edge still blocks issue this cycle.
  assign o_iss_ready = !busy_reg[i_iss_j] && !busy_reg[i_iss_k] && !busy_reg[i_iss_i];
  assign iss_fire    = i_iss_valid && o_iss_ready;

  assign o_rd_data = a_reg[i_rd_addr];
  assign o_busy    = busy_reg;

  addr_tag_pipe #(
    .LATENCY(LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iss_fire),
    .in_idx    (i_iss_i),
    .head_valid(head_valid),
    .head_idx  (head_idx)
  );

  // A retiring register is busy, so its host write is always dropped; the
  // writeback and host-write enables for one register never overlap.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    logic host_we;
    logic wb_we;
    logic iss_set;

    assign host_we = i_wr_en && (i_wr_addr == IDXW'(gi)) && !busy_reg[gi];
    assign wb_we   = head_valid && (head_idx == IDXW'(gi));
    assign iss_set = iss_fire && (i_iss_i == IDXW'(gi));

    assign a_we[gi]      = wb_we || host_we;
    assign a_wdata[gi]   = wb_we ? i_mul_Ai : i_wr_data;
    assign busy_next[gi] = iss_set || (busy_reg[gi] && !wb_we);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NREGS; n++) begin
        a_reg[n] <= '0;
      end
      busy_reg   <= '0;
      o_mul_Aj   <= '0;
      o_mul_Ak   <= '0;
      o_wb_valid <= 1'b0;
      o_wb_addr  <= '0;
      o_wr_err   <= 1'b0;
    end else begin
      for (int n = 0; n < NREGS; n++) begin
        if (a_we[n]) begin
          a_reg[n] <= a_wdata[n];
        end
      end
      busy_reg <= busy_next;
      // Operands see the register file before this edge's writes land.
      if (iss_fire) begin
        o_mul_Aj <= a_reg[i_iss_j];
        o_mul_Ak <= a_reg[i_iss_k];
      end
      o_wb_valid <= head_valid;
      if (head_valid) begin
        o_wb_addr <= head_idx;
      end
      o_wr_err <= i_wr_en && busy_reg[i_wr_addr];
    end
  end

endmodule

// File: tb/tb_address_multiply_issue.sv
// Scoreboard bench: a behavioural model predicts each writeback and a monitor
// compares it when o_wb_valid rises; directed cases plus a random phase.
module tb_address_multiply_issue;

  localparam int LAT = 6;

  logic        clk;
  logic        rst_n;
  logic        i_iss_valid;
  logic        o_iss_ready;
  logic [2:0]  i_iss_i, i_iss_j, i_iss_k;
  logic [31:0] o_mul_Aj, o_mul_Ak, i_mul_Ai;
  logic        i_wr_en;
  logic [2:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        o_wr_err;
  logic [2:0]  i_rd_addr;
  logic [31:0] o_rd_data;
  logic [7:0]  o_busy;
  logic        o_wb_valid;
  logic [2:0]  o_wb_addr;

  logic [2:0]  rd_sel;
  // The monitor needs the read port during writeback cycles to see the product.
  assign i_rd_addr = o_wb_valid ? o_wb_addr : rd_sel;

  address_multiply_issue #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_iss_valid(i_iss_valid), .o_iss_ready(o_iss_ready),
    .i_iss_i(i_iss_i), .i_iss_j(i_iss_j), .i_iss_k(i_iss_k),
    .o_mul_Aj(o_mul_Aj), .o_mul_Ak(o_mul_Ak), .i_mul_Ai(i_mul_Ai),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_err(o_wr_err),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_busy(o_busy), .o_wb_valid(o_wb_valid), .o_wb_addr(o_wb_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External multiplier stand-in: product presented LAT edges after launch.
  logic [31:0] mpipe [LAT-1];
  always @(posedge clk) begin
    mpipe[0] <= o_mul_Aj * o_mul_Ak;
    for (int n = 1; n < LAT - 1; n++) mpipe[n] <= mpipe[n-1];
  end
  assign i_mul_Ai = mpipe[LAT-2];

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] val;
    int          due;
  } fl_t;
  typedef struct {
    logic [2:0]  idx;
    logic [31:0] val;
  } wb_t;

  fl_t         infl[$];
  wb_t         sbq[$];
  logic [31:0] am [8];
  logic [7:0]  bm;
  logic        exp_err;
  int          cyc;
  int          checks;
  int          errors;
  int          wb_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers, reservations and in-flight products by due cycle.
  initial forever begin
    logic [31:0] am_old [8];
    logic [7:0]  bm_old;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int n = 0; n < 8; n++) am[n] = '0;
      bm = '0;
      exp_err = 1'b0;
      cyc = 0;
      infl.delete();
      sbq.delete();
    end else begin
      am_old = am;
      bm_old = bm;
      exp_err = i_wr_en && bm_old[i_wr_addr];
      if (i_wr_en && !bm_old[i_wr_addr]) am[i_wr_addr] = i_wr_data;
      if (infl.size() > 0 && infl[0].due == cyc) begin
        am[infl[0].idx] = infl[0].val;
        bm[infl[0].idx] = 1'b0;
        void'(infl.pop_front());
      end
      if (i_iss_valid && !bm_old[i_iss_i] && !bm_old[i_iss_j] && !bm_old[i_iss_k]) begin
        fl_t f;
        wb_t w;
        f.idx = i_iss_i;
        f.val = am_old[i_iss_j] * am_old[i_iss_k];
        f.due = cyc + LAT;
        w.idx = f.idx;
        w.val = f.val;
        bm[i_iss_i] = 1'b1;
        infl.push_back(f);
        sbq.push_back(w);
      end
      cyc++;
    end
  end

  // Monitor: compares on the falling edge, between active edges.
  initial forever begin
    wb_t e;
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (o_wb_valid) begin
        wb_seen++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected actual_addr=%0d required=none t=%0t", o_wb_addr, $time);
        end else begin
          e = sbq.pop_front();
          chk("wb_addr", 32'(o_wb_addr), 32'(e.idx));
          chk("wb_data", o_rd_data, e.val);
        end
      end
      chk("busy", 32'(o_busy), 32'(bm));
      chk("wr_err", 32'(o_wr_err), 32'(exp_err));
      if (i_iss_valid)
        chk("iss_ready", 32'(o_iss_ready),
            32'(!bm[i_iss_i] && !bm[i_iss_j] && !bm[i_iss_k]));
    end
  end

  task automatic host_wr(input logic [2:0] a, input logic [31:0] d);
    i_wr_en = 1'b1;
    i_wr_addr = a;
    i_wr_data = d;
    @(posedge clk);
    #1;
    i_wr_en = 1'b0;
    $display("host write A%0d=0x%08h", a, d);
  endtask

  task automatic issue(input logic [2:0] i, input logic [2:0] j, input logic [2:0] k,
                       output int waited);
    logic rdy;
    i_iss_valid = 1'b1;
    i_iss_i = i;
    i_iss_j = j;
    i_iss_k = k;
    waited = 0;
    rdy = 1'b0;
    while (!rdy && waited < 40) begin
      @(negedge clk);
      rdy = o_iss_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    i_iss_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=not_ready required=accept i=%0d", i);
    end
    $display("issue A%0d <- A%0d*A%0d after %0d edge(s)", i, j, k, waited);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] v);
    rd_sel = a;
    @(negedge clk);
    v = o_rd_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    int w;
    int wb0;
    checks = 0;
    errors = 0;
    wb_seen = 0;
    rst_n = 1'b0;
    i_iss_valid = 1'b0;
    i_iss_i = '0; i_iss_j = '0; i_iss_k = '0;
    i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    rd_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    for (int n = 0; n < 8; n++) begin
      read_reg(3'(n), v);
      chk("reset_rd", v, 32'd0);
    end
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_ready", 32'(o_iss_ready), 32'd1);
    chk("reset_wb_valid", 32'(o_wb_valid), 32'd0);

    // Basic product, then a RAW-dependent issue
    host_wr(3'd1, 32'd7);
    host_wr(3'd2, 32'd9);
    issue(3'd3, 3'd1, 3'd2, w);
    chk("basic_no_stall", 32'(w), 32'd1);
    chk("basic_busy3", 32'(o_busy[3]), 32'd1);
    issue(3'd4, 3'd3, 3'd3, w);
    chk("raw_stall_edges", 32'(w), 32'd7);
    drain();
    read_reg(3'd3, v);
    chk("basic_A3", v, 32'd63);
    read_reg(3'd4, v);
    chk("raw_A4", v, 32'd3969);

    // Six back-to-back issues to distinct registers
    host_wr(3'd0, 32'hFFFF_FFFF);
    host_wr(3'd7, 32'd2);
    wb0 = wb_seen;
    for (int n = 1; n <= 6; n++) begin
      issue(3'(n), 3'd0, 3'd7, w);
      chk("pipe_no_stall", 32'(w), 32'd1);
    end
    drain();
    chk("pipe_wb_count", 32'(wb_seen - wb0), 32'd6);
    for (int n = 1; n <= 6; n++) begin
      read_reg(3'(n), v);
      chk("pipe_Ai", v, 32'hFFFF_FFFE);
    end

    // Host write to a reserved register is dropped
    issue(3'd5, 3'd7, 3'd7, w);
    host_wr(3'd5, 32'h55);
    chk("conflict_err_pulse", 32'(o_wr_err), 32'd1);
    @(posedge clk);
    #1;
    chk("conflict_err_clear", 32'(o_wr_err), 32'd0);
    drain();
    read_reg(3'd5, v);
    chk("conflict_A5", v, 32'd4);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      i_iss_valid = ($urandom_range(0, 9) < 7);
      i_iss_i = 3'($urandom_range(0, 7));
      i_iss_j = 3'($urandom_range(0, 7));
      i_iss_k = 3'($urandom_range(0, 7));
      i_wr_en = ($urandom_range(0, 3) == 0);
      i_wr_addr = 3'($urandom_range(0, 7));
      i_wr_data = $urandom;
      @(posedge clk);
      #1;
    end
    i_iss_valid = 1'b0;
    i_wr_en = 1'b0;
    drain();
    for (int n = 0; n < 8; n++) begin
      read_reg(3'(n), v);
      chk("random_final", v, am[n]);
    end

    // Reset while a product is in flight
    host_wr(3'd0, 32'hFFFF_FFFF);
    host_wr(3'd7, 32'd2);
    issue(3'd2, 3'd0, 3'd7, w);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    rd_sel = 3'd0;
    #1;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_wb_valid", 32'(o_wb_valid), 32'd0);
    chk("midrst_mul_Aj", o_mul_Aj, 32'd0);
    chk("midrst_mul_Ak", o_mul_Ak, 32'd0);
    chk("midrst_rd", o_rd_data, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wb0 = wb_seen;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_wb", 32'(wb_seen - wb0), 32'd0);
    for (int n = 0; n < 8; n++) begin
      read_reg(3'(n), v);
      chk("midrst_regs", v, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
